// File: rtl/gpio_access_arbiter.sv
// Round-robin arbiter sharing one GPIO bank: owns the data/direction shadow registers and
// serialises masked read/write transactions. Optional owner lock enabled by GPIO_ARB_LOCK_EN.
module gpio_access_arbiter #(
   parameter  int WIDTH         = 16,
   parameter  int NREQ          = 4,
   parameter  int SETTLE_CYCLES = 2,
   localparam int IDW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ-1:0]       req_write,
   input  logic [NREQ-1:0]       req_dir,
   input  logic [NREQ*WIDTH-1:0] req_mask,
   input  logic [NREQ*WIDTH-1:0] req_wdata,
`ifdef GPIO_ARB_LOCK_EN
   input  logic [NREQ-1:0]       req_lock,
`endif
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic [WIDTH-1:0]      gpio_data,
   output logic [WIDTH-1:0]      gpio_dir,
   input  logic [WIDTH-1:0]      gpio_rd
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    id_q, id_d;
   logic              wr_q, wr_d;
   logic              dir_q, dir_d;
   logic [WIDTH-1:0]  mask_q, mask_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [NREQ-1:0]   req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]    rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic [WIDTH-1:0]  gpio_data_q, gpio_data_d;
   logic [WIDTH-1:0]  gpio_dir_q, gpio_dir_d;
   logic [NREQ-1:0]   elig_s;
   logic [IDW-1:0]    win_s;
`ifdef GPIO_ARB_LOCK_EN
   logic              lock_q, lock_d;
   logic [IDW-1:0]    owner_q, owner_d;
   logic [NREQ-1:0]   owner_oh_s;
`endif

   function automatic logic [WIDTH-1:0] masked_merge(input logic [WIDTH-1:0] old_val,
                                                     input logic [WIDTH-1:0] new_val,
                                                     input logic [WIDTH-1:0] mask);
      return (old_val & ~mask) | (new_val & mask);
   endfunction

   // Scanning downwards lets the nearest requester after ptr overwrite farther ones.
   function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                              input logic [IDW-1:0]  ptr);
      logic [IDW-1:0] pick;
      logic [IDW-1:0] idx;
      pick = ptr;
      for (int k = NREQ; k >= 1; k--) begin
         idx  = IDW'((int'(ptr) + k) % NREQ);
         pick = vld[idx] ? idx : pick;
      end
      return pick;
   endfunction

   // Eligible requesters and round-robin winner.
   always_comb begin
`ifdef GPIO_ARB_LOCK_EN
      owner_oh_s          = {NREQ{1'b0}};
      owner_oh_s[owner_q] = 1'b1;
      elig_s              = lock_q ? (req_valid & owner_oh_s) : req_valid;
`else
      elig_s              = req_valid;
`endif
      win_s = rr_pick(elig_s, ptr_q);
   end

   // Transaction FSM next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      wr_d        = wr_q;
      dir_d       = dir_q;
      mask_d      = mask_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      req_ready_d = {NREQ{1'b0}};
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_rdata_d = rsp_rdata_q;
      gpio_data_d = gpio_data_q;
      gpio_dir_d  = gpio_dir_q;
`ifdef GPIO_ARB_LOCK_EN
      lock_d      = lock_q;
      owner_d     = owner_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (|elig_s) begin
               id_d               = win_s;
               ptr_d              = win_s;
               wr_d               = req_write[win_s];
               dir_d              = req_dir[win_s];
               mask_d             = req_mask[int'(win_s)*WIDTH +: WIDTH];
               wdata_d            = req_wdata[int'(win_s)*WIDTH +: WIDTH];
               req_ready_d[win_s] = 1'b1;
`ifdef GPIO_ARB_LOCK_EN
               // While locked only the owner can win, so this both takes and releases the lock.
               lock_d             = req_lock[win_s];
               owner_d            = win_s;
`endif
               state_d            = ST_GRANT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (wr_q) begin
               if (dir_q) begin
                  gpio_dir_d  = masked_merge(gpio_dir_q, wdata_q, mask_q);
                  rsp_rdata_d = masked_merge(gpio_dir_q, wdata_q, mask_q);
               end else begin
                  gpio_data_d = masked_merge(gpio_data_q, wdata_q, mask_q);
                  rsp_rdata_d = masked_merge(gpio_data_q, wdata_q, mask_q);
               end
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               state_d     = ST_RESP;
            end else if (dir_q) begin
               rsp_rdata_d = gpio_dir_q;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               state_d     = ST_RESP;
            end else begin
               cnt_d   = 4'(SETTLE_CYCLES - 1);
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == 4'd0) begin
               rsp_rdata_d = gpio_rd;
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               state_d     = ST_RESP;
            end else begin
               cnt_d   = cnt_q - 4'd1;
               state_d = ST_SETTLE;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= IDW'(NREQ - 1);
         id_q        <= {IDW{1'b0}};
         wr_q        <= 1'b0;
         dir_q       <= 1'b0;
         mask_q      <= {WIDTH{1'b0}};
         wdata_q     <= {WIDTH{1'b0}};
         cnt_q       <= 4'd0;
         req_ready_q <= {NREQ{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= {IDW{1'b0}};
         rsp_rdata_q <= {WIDTH{1'b0}};
         gpio_data_q <= {WIDTH{1'b0}};
         gpio_dir_q  <= {WIDTH{1'b0}};
`ifdef GPIO_ARB_LOCK_EN
         lock_q      <= 1'b0;
         owner_q     <= {IDW{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         wr_q        <= wr_d;
         dir_q       <= dir_d;
         mask_q      <= mask_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rdata_q <= rsp_rdata_d;
         gpio_data_q <= gpio_data_d;
         gpio_dir_q  <= gpio_dir_d;
`ifdef GPIO_ARB_LOCK_EN
         lock_q      <= lock_d;
         owner_q     <= owner_d;
`endif
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_rdata = rsp_rdata_q;
   assign gpio_data = gpio_data_q;
   assign gpio_dir  = gpio_dir_q;

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Directed self-checking bench for gpio_access_arbiter (WIDTH=16, NREQ=4, SETTLE_CYCLES=2).
module tb_gpio_access_arbiter;

   localparam int WIDTH = 16;
   localparam int NREQ  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid, req_write, req_dir, req_lock;
   logic [63:0] req_mask, req_wdata;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_rdata, gpio_data, gpio_dir, gpio_rd;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          grant_cyc, rsp_cyc;
   logic [3:0]  got_ready;
   logic [1:0]  got_id;
   logic [15:0] got_rdata, snap_data, snap_dir;

   always #5 clk = ~clk;

   gpio_access_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .SETTLE_CYCLES(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_dir   (req_dir),
      .req_mask  (req_mask),
      .req_wdata (req_wdata),
`ifdef GPIO_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_rdata (rsp_rdata),
      .gpio_data (gpio_data),
      .gpio_dir  (gpio_dir),
      .gpio_rd   (gpio_rd)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Issue one transaction; cycle 0 is the IDLE cycle that sees the request.
   task automatic txn(input int id, input logic wr, input logic dir,
                      input logic [15:0] mask, input logic [15:0] wdata);
      @(posedge clk); #1;
      req_valid[id]            = 1'b1;
      req_write[id]            = wr;
      req_dir[id]              = dir;
      req_mask[id*16 +: 16]    = mask;
      req_wdata[id*16 +: 16]   = wdata;
      grant_cyc = -1;
      rsp_cyc   = -1;
      got_ready = 4'd0;
      for (int c = 0; c < 40 && rsp_cyc < 0; c++) begin
         @(negedge clk);
         if (req_ready != 4'd0 && grant_cyc < 0) begin
            grant_cyc     = c;
            got_ready     = req_ready;
            req_valid[id] = 1'b0;
         end
         if (c == 2) begin
            snap_data = gpio_data;
            snap_dir  = gpio_dir;
         end
         if (rsp_valid) begin
            rsp_cyc   = c;
            got_id    = rsp_id;
            got_rdata = rsp_rdata;
         end
      end
      req_valid[id] = 1'b0;
   endtask

   task automatic check_txn(input string tag, input int id, input int lat, input logic [15:0] exp_rdata);
      check({tag, " grant_cycle"}, grant_cyc, 32'd1);
      check({tag, " ready"}, {28'd0, got_ready}, 32'd1 << id);
      check({tag, " rsp_cycle"}, rsp_cyc, lat);
      check({tag, " rsp_id"}, {30'd0, got_id}, id);
      check({tag, " rdata"}, {16'd0, got_rdata}, {16'd0, exp_rdata});
   endtask

   initial begin
      int         exp_order[5];
      int         exp_lock[4];
      int         g, pulse_err, last_grant_cyc;
      logic [3:0] prev_ready;
      logic       saw_rsp;

      exp_order = '{0, 1, 2, 3, 0};
      exp_lock  = '{2, 2, 2, 0};
      reset     = 1'b0;
      req_valid = 4'd0;
      req_write = 4'd0;
      req_dir   = 4'd0;
      req_lock  = 4'd0;
      req_mask  = 64'd0;
      req_wdata = 64'd0;
      gpio_rd   = 16'h1234;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst gpio_data", gpio_data, 32'd0);
      check("rst gpio_dir", gpio_dir, 32'd0);
      check("rst req_ready", req_ready, 32'd0);
      check("rst rsp_valid", rsp_valid, 32'd0);
      check("rst rsp_id", rsp_id, 32'd0);
      check("rst rsp_rdata", rsp_rdata, 32'd0);

      txn(0, 1'b1, 1'b0, 16'hFFFF, 16'h5555);
      check_txn("wr_data", 0, 2, 16'h5555);
      check("wr_data gpio_data c2", snap_data, 32'h5555);

      txn(0, 1'b1, 1'b1, 16'hFFFF, 16'hF0F0);
      check_txn("wr_dir", 0, 2, 16'hF0F0);
      check("wr_dir gpio_dir c2", snap_dir, 32'hF0F0);

      txn(2, 1'b1, 1'b0, 16'h00FF, 16'hAAAA);
      check_txn("wr_mask", 2, 2, 16'h55AA);
      check("wr_mask gpio_data c2", snap_data, 32'h55AA);

      txn(1, 1'b1, 1'b0, 16'h0000, 16'hFFFF);
      check_txn("wr_zero", 1, 2, 16'h55AA);
      check("wr_zero gpio_data", gpio_data, 32'h55AA);

      txn(3, 1'b0, 1'b1, 16'hFFFF, 16'h0000);
      check_txn("rd_dir", 3, 2, 16'hF0F0);

      gpio_rd = 16'hA5A5;
      txn(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      check_txn("rd_pin", 1, 4, 16'hA5A5);

      // Pin read by req2 aborted by reset while settling.
      @(posedge clk); #1;
      req_valid[2] = 1'b1;
      req_write[2] = 1'b0;
      req_dir[2]   = 1'b0;
      saw_rsp      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      req_valid[2] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         saw_rsp = saw_rsp | rsp_valid;
      end
      check("abort gpio_data", gpio_data, 32'd0);
      check("abort gpio_dir", gpio_dir, 32'd0);
      check("abort rsp_rdata", rsp_rdata, 32'd0);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         saw_rsp = saw_rsp | rsp_valid;
      end
      check("abort no rsp", saw_rsp, 32'd0);

      // All four requesters held valid: dir reads, expect 0,1,2,3,0.
      @(posedge clk); #1;
      req_write      = 4'd0;
      req_dir        = 4'hF;
      req_valid      = 4'hF;
      g              = 0;
      pulse_err      = 0;
      prev_ready     = 4'd0;
      last_grant_cyc = -1;
      for (int c = 0; c < 40 && g < 5; c++) begin
         @(negedge clk);
         if (req_ready != 4'd0 && prev_ready != 4'd0) begin
            pulse_err++;
         end
         if (req_ready != 4'd0 && prev_ready == 4'd0) begin
            check($sformatf("rr grant %0d", g), req_ready, 32'd1 << exp_order[g]);
            g++;
            last_grant_cyc = c;
         end
         prev_ready = req_ready;
      end
      req_valid = 4'd0;
      check("rr grant count", g, 32'd5);
      check("rr fifth grant cycle", last_grant_cyc, 32'd13);
      @(negedge clk);
      check("rr single-cycle pulse", pulse_err + int'(req_ready != 4'd0), 32'd0);
      check("rr last rsp_id", rsp_id, 32'd0);
      repeat (3) @(negedge clk);

`ifdef GPIO_ARB_LOCK_EN
      // req2 locks; req0 waits until req2 releases.
      @(posedge clk); #1;
      req_write       = 4'b0100;
      req_dir         = 4'b0001;
      req_mask[47:32] = 16'h000F;
      req_wdata[47:32]= 16'h0003;
      req_lock        = 4'b0100;
      req_valid       = 4'b0101;
      g               = 0;
      prev_ready      = 4'd0;
      for (int c = 0; c < 60 && g < 4; c++) begin
         @(negedge clk);
         if (req_ready != 4'd0 && prev_ready == 4'd0) begin
            check($sformatf("lock grant %0d", g), req_ready, 32'd1 << exp_lock[g]);
            g++;
            if (g == 2) begin
               req_lock = 4'b0000;
            end
         end
         prev_ready = req_ready;
      end
      req_valid = 4'd0;
      check("lock grant count", g, 32'd4);
      repeat (4) @(negedge clk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gpio_access_arbiter.md
# gpio_access_arbiter

Shares one `gpio_npins` bank between up to NREQ software/hardware requesters. It owns the shadow data and direction registers that drive `gpio_npins.data_in` and `gpio_npins.dir_in`. It serialises masked read/write transactions with round-robin arbitration and returns a response per transaction. For pin reads it waits a programmable settle time before sampling `gpio_npins.gpio_pins_out`.

## Interface
Parameters:
- `WIDTH`, 16: GPIO bank width, matches `gpio_npins`.
- `NREQ`, 4: number of requesters, 2..8.
- `SETTLE_CYCLES`, 2: wait between grant and pin sample on pin reads, 1..15.

Ports:
- `clk` in 1: single clock, all logic rising-edge.
- `reset` in 1: reset is asynchronous and active-low; low forces every register to its reset value immediately.
- `req_valid` in NREQ: per-requester transaction request.
- `req_write` in NREQ: 1 = write, 0 = read.
- `req_dir` in NREQ: target; 0 = data register or pins, 1 = direction register.
- `req_mask` in NREQ*WIDTH: per-requester bit mask, slice i = [i*WIDTH +: WIDTH]; ignored on reads.
- `req_wdata` in NREQ*WIDTH: per-requester write data, same slicing.
- `req_ready` out NREQ: one-hot, 1-cycle grant pulse.
- `rsp_valid` out 1: 1-cycle response strobe.
- `rsp_id` out clog2(NREQ): requester index of the response.
- `rsp_rdata` out WIDTH: response data, held until the next response.
- `gpio_data` out WIDTH: to `gpio_npins.data_in`.
- `gpio_dir` out WIDTH: to `gpio_npins.dir_in`; 1 = output.
- `gpio_rd` in WIDTH: from `gpio_npins.gpio_pins_out`.

## Operation
- Reset values:
  - `gpio_data` = 0, `gpio_dir` = 0 (all pins input).
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_rdata` = 0.
  - FSM = IDLE; round-robin pointer = NREQ-1, so the first search starts at requester 0.
- FSM states:
  - IDLE: if any `req_valid`, pick the winner as the first set bit searching from pointer+1 with wrap-around. Latch the winner's id, write, dir, mask and wdata; pointer <= id; go to GRANT. Otherwise stay in IDLE.
  - GRANT: `req_ready[id]` = 1 for this cycle only.
    - Write to data: `gpio_data <= (gpio_data & ~mask) | (wdata & mask)`. Write to dir: the same update on `gpio_dir`. Both go to RESP.
    - Read with dir=1: go to RESP.
    - Read with dir=0: load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
  - SETTLE: decrement the counter; go to RESP when the counter = 0.
  - RESP: `rsp_valid` = 1 and `rsp_id` = id. Go to IDLE.
    - `rsp_rdata` = updated register value after a write.
    - `rsp_rdata` = `gpio_dir` after a dir read.
    - `rsp_rdata` = `gpio_rd` sampled on entry to RESP after a pin read.
- Requesters hold `req_valid` until they see `req_ready`. Fields are captured in IDLE, so changes after capture have no effect. Dropping `req_valid` after capture does not cancel the transaction.
- Only one transaction is in flight. Other requests wait, with no starvation: any valid requester is granted within NREQ transactions.
- A mask of 0 on a write leaves the register unchanged, but the transaction still completes with a response.
- Reset asserted mid-transaction aborts it with no response; the shadow registers return to 0.

## Timing
- Request first seen in IDLE at cycle 0. `req_ready` is high in cycle 1; a written register value is visible on `gpio_data`/`gpio_dir` from cycle 2.
- Write and dir-read latency: `rsp_valid` in cycle 2; back-to-back throughput is one transaction per 3 cycles.
- Pin-read latency: `rsp_valid` in cycle 2+SETTLE_CYCLES; `gpio_rd` is sampled at the edge that ends cycle 1+SETTLE_CYCLES.
- A request arriving in the RESP cycle is seen in the following IDLE cycle.
- Simultaneous requests in the same cycle are resolved by the pointer only.

## Configuration
- `GPIO_ARB_LOCK_EN` defined:
  - Adds input `req_lock` (NREQ bits).
  - A granted transaction with `req_lock[id]` = 1 makes `id` the exclusive owner. While locked, IDLE considers only the owner's `req_valid`.
  - A granted transaction from the owner with `req_lock` = 0 releases the lock after that transaction.
  - Reset clears the lock.
- Not defined: no `req_lock` port; pure round-robin.

## Test plan
- After reset release, req0 writes data, mask 0xFFFF, wdata 0x5555 -> `req_ready[0]` in cycle 1, `gpio_data` = 0x5555 in cycle 2, `rsp_valid` with `rsp_id`=0 and `rsp_rdata`=0x5555.
- Dir=0xF0F0, then a masked write with mask 0x00FF, wdata 0xAAAA -> `gpio_data` = 0x55AA with upper byte preserved; a dir read returns 0xF0F0 in cycle 2.
- Drive `gpio_rd`=0xA5A5 with SETTLE_CYCLES=2, then req1 pin read -> `rsp_valid` in cycle 4 with `rsp_rdata`=0xA5A5 and `rsp_id`=1.
- All four requesters valid simultaneously and held -> grant order 0,1,2,3,0, each `req_ready` a single-cycle one-hot pulse.
- Assert `reset` low during SETTLE -> `rsp_valid` never pulses, outputs return to 0, and the next grant goes to requester 0.
- With `GPIO_ARB_LOCK_EN`: req2 locks, req0 and req2 both valid -> only req2 is granted until it writes with lock=0, then req0 is granted.
